// File: rtl/nw_systolic_scorer.sv
`default_nettype none
// ============================================================================
// Module      : nw_systolic_scorer
// Description : Linear systolic Needleman-Wunsch global alignment scorer.
//               One PE per query character; subject streams through.
// Revision    : 1.0 - initial release
// ============================================================================
module nw_systolic_scorer #(
    parameter int PE_COUNT = 10,
    parameter int CWIDTH   = 2,
    parameter int SWIDTH   = 16,
    parameter int MATCH    = 1,
    parameter int MISMATCH = -1,
    parameter int INDEL    = -1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load_valid,
    output logic                              load_ready,
    input  logic [PE_COUNT*CWIDTH-1:0]        query,
    input  logic [$clog2(PE_COUNT+1)-1:0]     query_len,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [CWIDTH-1:0]                 s_char,
    input  logic                              s_last,
    output logic                              score_valid,
    input  logic                              score_ready,
    output logic [SWIDTH-1:0]                 score,
    output logic                              busy
);

    localparam int c_len_w = $clog2(PE_COUNT+1);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_stream = 2'd1;
    localparam logic [1:0] c_drain  = 2'd2;
    localparam logic [1:0] c_result = 2'd3;

    localparam logic signed [SWIDTH-1:0] c_indel    = SWIDTH'(INDEL);
    localparam logic signed [SWIDTH-1:0] c_match    = SWIDTH'(MATCH);
    localparam logic signed [SWIDTH-1:0] c_mismatch = SWIDTH'(MISMATCH);
    localparam logic [c_len_w-1:0]       c_pe_max   = c_len_w'(PE_COUNT);
    localparam logic [c_len_w-1:0]       c_one      = c_len_w'(1);

    logic [1:0]                  r_state;
    logic [PE_COUNT*CWIDTH-1:0]  r_query;
    logic [c_len_w-1:0]          r_qlen;
    logic [c_len_w-1:0]          r_cnt;
    logic signed [SWIDTH-1:0]    r_acc;
    logic signed [SWIDTH-1:0]    r_score;

    logic                        w_load;
    logic                        w_fire;
    logic [c_len_w-1:0]          w_qlen;
    logic signed [SWIDTH-1:0]    w_final;

    logic signed [SWIDTH-1:0]    w_h   [PE_COUNT];
    logic [CWIDTH-1:0]           w_chr [PE_COUNT];
    logic [PE_COUNT-1:0]         w_vld;
    logic                        w_unused;

    assign w_load = load_valid && (r_state == c_idle);
    assign w_fire = s_valid && (r_state == c_stream);
    assign w_qlen = (query_len > c_pe_max) ? c_pe_max : query_len;

    assign load_ready  = (r_state == c_idle);
    assign s_ready     = (r_state == c_stream);
    assign score_valid = (r_state == c_result);
    assign busy        = (r_state != c_idle);
    assign score       = r_score;

    // The tail PE's token has no downstream consumer.
    assign w_unused = ^{w_vld[PE_COUNT-1], w_chr[PE_COUNT-1]};

    always_comb begin
        w_final = r_acc;
        for (int k = 0; k < PE_COUNT; k++) begin
            if (r_qlen == c_len_w'(k + 1)) begin
                w_final = w_h[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_query <= '0;
            r_qlen  <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_score <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_load) begin
                        r_query <= query;
                        r_qlen  <= w_qlen;
                        r_acc   <= '0;
                        r_state <= c_stream;
                    end
                end
                c_stream: begin
                    if (w_fire) begin
                        r_acc <= r_acc + c_indel;
                        if (s_last) begin
                            r_cnt   <= r_qlen;
                            r_state <= c_drain;
                        end
                    end
                end
                c_drain: begin
                    // The final row settles when at most one PE hop remains.
                    if (r_cnt <= c_one) begin
                        r_score <= w_final;
                        r_state <= c_result;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                default: begin
                    if (score_ready) begin
                        r_state <= c_idle;
                    end
                end
            endcase
        end
    end

    for (genvar k = 0; k < PE_COUNT; k++) begin : g_pe
        localparam logic signed [SWIDTH-1:0] c_h_init  = SWIDTH'((k + 1) * INDEL);
        localparam logic signed [SWIDTH-1:0] c_up_init = SWIDTH'(k * INDEL);

        logic signed [SWIDTH-1:0] r_h;
        logic signed [SWIDTH-1:0] r_up;
        logic [CWIDTH-1:0]        r_chr;
        logic                     r_vld;

        logic                     w_vld_in;
        logic [CWIDTH-1:0]        w_chr_in;
        logic signed [SWIDTH-1:0] w_up_in;
        logic signed [SWIDTH-1:0] w_diag;
        logic signed [SWIDTH-1:0] w_left;
        logic signed [SWIDTH-1:0] w_upper;
        logic signed [SWIDTH-1:0] w_best;

        if (k == 0) begin : g_head
            assign w_vld_in = w_fire;
            assign w_chr_in = s_char;
            assign w_up_in  = r_acc + c_indel;
        end else begin : g_link
            assign w_vld_in = w_vld[k-1];
            assign w_chr_in = w_chr[k-1];
            assign w_up_in  = w_h[k-1];
        end

        assign w_diag  = r_up + ((r_query[k*CWIDTH +: CWIDTH] == w_chr_in) ? c_match : c_mismatch);
        assign w_left  = r_h + c_indel;
        assign w_upper = w_up_in + c_indel;

        always_comb begin
            w_best = w_diag;
            if (w_left > w_best) begin
                w_best = w_left;
            end
            if (w_upper > w_best) begin
                w_best = w_upper;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_h   <= '0;
                r_up  <= '0;
                r_chr <= '0;
                r_vld <= 1'b0;
            end else if (w_load) begin
                r_h   <= c_h_init;
                r_up  <= c_up_init;
                r_vld <= 1'b0;
            end else begin
                r_vld <= w_vld_in;
                if (w_vld_in) begin
                    r_h   <= w_best;
                    r_up  <= w_up_in;
                    r_chr <= w_chr_in;
                end
            end
        end

        assign w_h[k]   = r_h;
        assign w_chr[k] = r_chr;
        assign w_vld[k] = r_vld;
    end

endmodule
`default_nettype wire

// File: tb/tb_nw_systolic_scorer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nw_systolic_scorer
// Description : Directed vector bench for nw_systolic_scorer (PE_COUNT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nw_systolic_scorer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [7:0]  query = '0;
    logic [2:0]  query_len = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [1:0]  s_char = '0;
    logic        s_last = 1'b0;
    logic        score_valid;
    logic        score_ready = 1'b0;
    logic [15:0] score;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  q;
        logic [2:0]  qlen;
        int          n;
        logic [7:0]  s;
        int          gap;
        int          hold;
        logic [15:0] exp_score;
        int          exp_lat;
    } vec_t;

    vec_t vecs [9];

    nw_systolic_scorer #(
        .PE_COUNT(4), .CWIDTH(2), .SWIDTH(16),
        .MATCH(1), .MISMATCH(-1), .INDEL(-1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready),
        .query(query), .query_len(query_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_char(s_char), .s_last(s_last),
        .score_valid(score_valid), .score_ready(score_ready),
        .score(score), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " load_ready"},  32'(load_ready),  32'd1);
        chk({tag, " s_ready"},     32'(s_ready),     32'd0);
        chk({tag, " score_valid"}, 32'(score_valid), 32'd0);
        chk({tag, " score"},       32'(score),       32'd0);
        chk({tag, " busy"},        32'(busy),        32'd0);
    endtask

    task automatic run_job(input int idx, input vec_t v);
        logic [15:0] held;
        int lat;
        @(negedge clk);
        chk($sformatf("v%0d load_ready idle", idx), 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        query      = v.q;
        query_len  = v.qlen;
        @(negedge clk);
        load_valid = 1'b0;
        chk($sformatf("v%0d s_ready stream", idx), 32'(s_ready), 32'd1);
        for (int j = 0; j < v.n; j++) begin
            s_valid = 1'b1;
            s_char  = v.s[2*j +: 2];
            s_last  = (j == v.n - 1);
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (j != v.n - 1) begin
                repeat (v.gap) @(negedge clk);
            end
        end
        chk($sformatf("v%0d s_ready after last", idx), 32'(s_ready), 32'd0);
        lat = 0;
        while (!score_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d score", idx), 32'(score), 32'(v.exp_score));
        held = score;
        for (int h = 0; h < v.hold; h++) begin
            load_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d hold%0d score", idx, h), 32'(score), 32'(v.exp_score));
            chk($sformatf("v%0d hold%0d stable", idx, h), 32'(score), 32'(held));
            chk($sformatf("v%0d hold%0d score_valid", idx, h), 32'(score_valid), 32'd1);
            chk($sformatf("v%0d hold%0d s_ready", idx, h), 32'(s_ready), 32'd0);
            chk($sformatf("v%0d hold%0d load_ready", idx, h), 32'(load_ready), 32'd0);
            chk($sformatf("v%0d hold%0d busy", idx, h), 32'(busy), 32'd1);
        end
        load_valid  = 1'b0;
        score_ready = 1'b1;
        @(negedge clk);
        score_ready = 1'b0;
        chk($sformatf("v%0d load_ready after handshake", idx), 32'(load_ready), 32'd1);
        chk($sformatf("v%0d score_valid after handshake", idx), 32'(score_valid), 32'd0);
        chk($sformatf("v%0d busy after handshake", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        // query char i at q[2i+:2]; subject char j at s[2j+:2]
        vecs[0] = '{8'hE4, 3'd4, 4, 8'hE4, 0, 0, 16'h0004, 4};  // 0123 vs 0123
        vecs[1] = '{8'hE4, 3'd4, 4, 8'h1B, 0, 0, 16'hFFFD, 4};  // 0123 vs 3210
        vecs[2] = '{8'hE4, 3'd4, 4, 8'h1B, 1, 0, 16'hFFFD, 4};  // same, with bubbles
        vecs[3] = '{8'h00, 3'd2, 1, 8'h00, 0, 0, 16'h0000, 2};  // 00 vs 0
        vecs[4] = '{8'hE4, 3'd0, 3, 8'h27, 0, 0, 16'hFFFD, 1};  // empty query
        vecs[5] = '{8'hE4, 3'd7, 4, 8'hE4, 0, 0, 16'h0004, 4};  // length clamp
        vecs[6] = '{8'h09, 3'd2, 4, 8'hE4, 0, 0, 16'h0000, 2};  // 12 vs 0123
        vecs[7] = '{8'hE4, 3'd4, 3, 8'h34, 2, 0, 16'h0002, 4};  // 0123 vs 013
        vecs[8] = '{8'hE4, 3'd4, 4, 8'hE4, 0, 5, 16'h0004, 4};  // held result

        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Subject beats in IDLE must not move the FSM
        s_valid = 1'b1;
        s_last  = 1'b1;
        repeat (2) @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("idle s_valid load_ready", 32'(load_ready), 32'd1);
        chk("idle s_valid busy", 32'(busy), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_job(i, vecs[i]);
        end

        // Mid-stream asynchronous reset
        @(negedge clk);
        load_valid = 1'b1;
        query      = 8'hE4;
        query_len  = 3'd4;
        @(negedge clk);
        load_valid = 1'b0;
        s_valid    = 1'b1;
        s_char     = 2'd0;
        @(negedge clk);
        s_char     = 2'd1;
        @(negedge clk);
        s_valid    = 1'b0;
        chk("pre-reset busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_job(100, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nw_systolic_scorer.md
# nw_systolic_scorer

Parametrised linear systolic Needleman-Wunsch scoring engine and the next generation of the fixed-size grid. `PE_COUNT` processing elements (PEs) each hold one query character. The subject sequence streams through one character per accepted beat, so subject length is unbounded by array size. Valid/ready handshakes on query load, subject stream and result let the block sit between a sequence DMA front end and a result collector.

## Interface
- `PE_COUNT`, 10: number of PEs; the maximum query length.
- `CWIDTH`, 2: bits per character.
- `SWIDTH`, 16: bits per signed score, two's complement.
- `MATCH`, 1: signed score for a match.
- `MISMATCH`, -1: signed score for a mismatch.
- `INDEL`, -1: signed score for an insertion or deletion.
- `clk` in 1: clock.
- `rst_n` in 1: reset; one clock, reset is asynchronous and active-low.
- `load_valid` in 1: query load request.
- `load_ready` out 1: high in IDLE only.
- `query` in PE_COUNT*CWIDTH: query characters; character i is at `[i*CWIDTH +: CWIDTH]`.
- `query_len` in $clog2(PE_COUNT+1): active query length, 0..PE_COUNT.
- `s_valid` in 1: subject character valid.
- `s_ready` out 1: high in STREAM only.
- `s_char` in CWIDTH: subject character.
- `s_last` in 1: marks the final subject character.
- `score_valid` out 1: result valid.
- `score_ready` in 1: result accepted.
- `score` out SWIDTH: final global alignment score H(query_len, n).
- `busy` out 1: high in every state except IDLE.

## Operation
- Recurrence: H(0,j) = j*INDEL and H(i,0) = i*INDEL.
- H(i,j) = max(H(i-1,j-1) + (q[i-1]==t[j-1] ? MATCH : MISMATCH), H(i-1,j) + INDEL, H(i,j-1) + INDEL).
- All arithmetic is SWIDTH-bit, wraps on overflow, and uses a signed compare.
- PE k computes row k+1. It holds:
  - the previous own output, H(k+1,j-1), initialised at load to (k+1)*INDEL;
  - the previous upstream value, initialised to k*INDEL.
- Each beat, the character, a valid bit and H(k+1,j) move to PE k+1.
- PE 0 takes its upstream value from a boundary accumulator that starts at 0 and adds INDEL on each accepted character.
- PEs update only on a valid token. Bubbles on `s_valid` are legal and do not change the result.
- FSM states: IDLE → STREAM → DRAIN → RESULT → IDLE.
  - IDLE: on `load_valid && load_ready`, register `query` and `query_len`, initialise PE boundaries and the accumulator, go to STREAM.
  - STREAM: accept a character on `s_valid && s_ready`. On an accepted beat with `s_last`=1, go to DRAIN and load the drain counter with `query_len`.
  - DRAIN: decrement the counter each cycle. At 0, capture the output of PE query_len-1 into `score` and go to RESULT. With `query_len`=0, capture the accumulator value instead.
  - RESULT: hold `score_valid`=1 and keep `score` stable until `score_ready`, then go to IDLE.
- `query_len` > PE_COUNT is clamped to PE_COUNT at load.
- PEs at index ≥ `query_len` still compute, but their outputs are ignored.
- `s_valid` outside STREAM and `load_valid` outside IDLE are ignored; no state change.
- Query registers keep their contents after a job. A new load overwrites them.

## Timing
- Reset values: state IDLE, `load_ready`=1, `s_ready`=0, `score_valid`=0, `score`=0, `busy`=0. All PE registers and valid bits clear.
- Reset asserted mid-job aborts immediately. No partial result is ever presented.
- `load_ready`, `s_ready` and `busy` are decoded from registered state, with no combinational path from inputs.
- PE k registers H(k+1,j) k cycles after the edge that accepts t[j-1]. PE 0 registers on the accepting edge itself.
- `score_valid` rises max(query_len,1) cycles after the edge that accepts the `s_last` beat.
- `s_ready` falls on that same edge, so at most one job is in flight.
- Back-to-back: the cycle after the `score` handshake, `load_ready`=1.
- Throughput: one character per cycle while `s_valid` is held high.

## Test plan
Common settings: PE_COUNT=4, CWIDTH=2, SWIDTH=16, MATCH=1, MISMATCH=INDEL=-1.
1. Query {0,1,2,3}, len 4; stream 0,1,2,3 with `s_valid` held high → `score`=4, `score_valid` 4 cycles after the `s_last` accept.
2. Query {0,1,2,3}; stream 3,2,1,0 → `score`=-3 (0xFFFD). Repeat with an idle cycle inserted between each beat → same score and same latency from `s_last`.
3. Query {0,0}, len 2; single beat 0 with `s_last`=1 → `score`=0, `score_valid` 2 cycles later.
4. `query_len`=0; stream 3 arbitrary characters → `score`=-3 one cycle after the `s_last` accept.
5. Hold `score_ready` low for 5 cycles in RESULT → `score` stable, `s_ready`=0, `load_ready`=0, `busy`=1. Raise `score_ready` → next cycle IDLE, `load_ready`=1.
6. Drop `rst_n` for 1 cycle mid-STREAM → all outputs at reset values asynchronously. Then run scenario 1 again → `score`=4 with nominal latency.
